// File: rtl/ro_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ro_buffer
//  Description : 16-entry reorder buffer. Allocates entries in program order
//                from the issuer, collects results from the ALU (rss) and
//                load/store (lsb) broadcast buses, and retires at most one
//                entry per cycle in order to the register file. A retiring
//                branch whose resolved next pc differs from its prediction
//                flushes the whole buffer and pulses a redirect to all units.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst, rdy                  clock, sync active-high reset, global stall
//    is_issue_from_issuer ...       allocation request (rd, pred_pc, is_branch)
//    next_rob_id_to_issuer          id the next allocation will receive (1..16)
//    is_ro_buffer_full              back-pressure to the issuer (count >= 15)
//    *_from_rss_bus                 ALU result broadcast (dest, value, next_pc)
//    *_from_lsb_bus                 load/store result broadcast (dest, value)
//    *_to_reg_file                  commit port (dest 0 = no commit)
//    reset_to_rob_bus, target_pc_*  one-cycle flush pulse and redirect pc
// ============================================================================
module ro_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        is_issue_from_issuer,
    input  logic [4:0]  rd_from_issuer,
    input  logic [31:0] pred_pc_from_issuer,
    input  logic        is_branch_from_issuer,
    output logic [4:0]  next_rob_id_to_issuer,
    output logic        is_ro_buffer_full,
    input  logic [4:0]  dest_from_rss_bus,
    input  logic [31:0] value_from_rss_bus,
    input  logic [31:0] next_pc_from_rss_bus,
    input  logic [4:0]  dest_from_lsb_bus,
    input  logic [31:0] value_from_lsb_bus,
    output logic [4:0]  dest_to_reg_file,
    output logic [4:0]  rd_to_reg_file,
    output logic [31:0] value_to_reg_file,
    output logic        reset_to_rob_bus,
    output logic [31:0] target_pc_to_rob_bus
);

    localparam int         c_DEPTH     = 16;
    localparam logic [4:0] c_DEPTH_CNT = 5'd16;
    localparam logic [4:0] c_FULL_CNT  = 5'd15;

    // ------------------------------------------------------------------
    // Queue control state
    // ------------------------------------------------------------------
    logic [3:0]         r_head;
    logic [3:0]         r_tail;
    logic [4:0]         r_count;
    logic [c_DEPTH-1:0] r_ready;

    // Entry payload (no reset needed: only meaningful while busy)
    logic [4:0]         r_rd      [c_DEPTH];
    logic [31:0]        r_pred_pc [c_DEPTH];
    logic [31:0]        r_next_pc [c_DEPTH];
    logic [31:0]        r_value   [c_DEPTH];
    logic [c_DEPTH-1:0] r_is_branch;

    // Registered outputs
    logic [4:0]         r_dest_out;
    logic [4:0]         r_rd_out;
    logic [31:0]        r_val_out;
    logic               r_flush;
    logic [31:0]        r_target;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [c_DEPTH-1:0] w_busy;
    logic [c_DEPTH-1:0] w_rss_hit;
    logic [c_DEPTH-1:0] w_lsb_hit;
    logic               w_commit;
    logic               w_mispredict;
    logic               w_accept;
    logic               w_issue;
    logic [4:0]         w_head_id;

    // An entry is busy when its distance from head is below the occupancy.
    generate
        for (genvar k = 0; k < c_DEPTH; k++) begin : g_entry
            logic [3:0] w_off;
            assign w_off        = 4'(k) - r_head;
            assign w_busy[k]    = ({1'b0, w_off} < r_count);
            assign w_rss_hit[k] = w_accept && w_busy[k] &&
                                  (dest_from_rss_bus == 5'(k + 1));
            assign w_lsb_hit[k] = w_accept && w_busy[k] &&
                                  (dest_from_lsb_bus == 5'(k + 1));
        end
    endgenerate

    // Commit looks only at the registered ready bit, so a writeback to the
    // head entry retires on the following cycle at the earliest.
    assign w_commit     = (r_count != 5'd0) && r_ready[r_head];
    assign w_mispredict = w_commit && r_is_branch[r_head] &&
                          (r_next_pc[r_head] != r_pred_pc[r_head]);

    // Issue and writeback are discarded in the mispredict cycle and in the
    // flush-pulse cycle that follows it.
    assign w_accept  = !r_flush && !w_mispredict;
    assign w_issue   = w_accept && is_issue_from_issuer && (r_count < c_DEPTH_CNT);
    assign w_head_id = {1'b0, r_head} + 5'd1;

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= 4'd0;
            r_tail     <= 4'd0;
            r_count    <= 5'd0;
            r_ready    <= '0;
            r_dest_out <= 5'd0;
            r_rd_out   <= 5'd0;
            r_val_out  <= 32'd0;
            r_flush    <= 1'b0;
            r_target   <= 32'd0;
        end else if (rdy) begin
            r_flush  <= w_mispredict;
            r_target <= w_mispredict ? r_next_pc[r_head] : 32'd0;

            // A mispredicting branch still writes its own destination.
            if (w_commit) begin
                r_dest_out <= w_head_id;
                r_rd_out   <= r_rd[r_head];
                r_val_out  <= r_value[r_head];
            end else begin
                r_dest_out <= 5'd0;
                r_rd_out   <= 5'd0;
                r_val_out  <= 32'd0;
            end

            if (w_mispredict) begin
                r_head  <= 4'd0;
                r_tail  <= 4'd0;
                r_count <= 5'd0;
                r_ready <= '0;
            end else begin
                r_head  <= r_head + 4'(w_commit);
                r_tail  <= r_tail + 4'(w_issue);
                r_count <= r_count + 5'(w_issue) - 5'(w_commit);
                // Order matters: a retiring entry must leave with ready
                // cleared even if a late writeback hits it in the same cycle.
                for (int k = 0; k < c_DEPTH; k++) begin
                    if (w_rss_hit[k] || w_lsb_hit[k]) begin
                        r_ready[k] <= 1'b1;
                    end
                    if (w_commit && (r_head == 4'(k))) begin
                        r_ready[k] <= 1'b0;
                    end
                    if (w_issue && (r_tail == 4'(k))) begin
                        r_ready[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_issue) begin
                r_rd[r_tail]        <= rd_from_issuer;
                r_pred_pc[r_tail]   <= pred_pc_from_issuer;
                // Default resolved pc to the prediction so a branch that only
                // ever receives an lsb result never reports a mispredict.
                r_next_pc[r_tail]   <= pred_pc_from_issuer;
                r_value[r_tail]     <= 32'd0;
                r_is_branch[r_tail] <= is_branch_from_issuer;
            end
            for (int k = 0; k < c_DEPTH; k++) begin
                if (w_rss_hit[k]) begin
                    r_value[k]   <= value_from_rss_bus;
                    r_next_pc[k] <= next_pc_from_rss_bus;
                end
                if (w_lsb_hit[k]) begin
                    r_value[k] <= value_from_lsb_bus;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign next_rob_id_to_issuer = {1'b0, r_tail} + 5'd1;
    assign is_ro_buffer_full     = (r_count >= c_FULL_CNT);
    assign dest_to_reg_file      = r_dest_out;
    assign rd_to_reg_file        = r_rd_out;
    assign value_to_reg_file     = r_val_out;
    assign reset_to_rob_bus      = r_flush;
    assign target_pc_to_rob_bus  = r_target;

endmodule
`default_nettype wire

// File: tb/tb_ro_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_buffer
//  Description : Directed, table-driven bench for ro_buffer. Each record holds
//                the inputs for one clock edge and the outputs expected just
//                after that edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ro_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, iss, br;
    logic [4:0]  rd, rss_dest, lsb_dest;
    logic [31:0] ppc, rss_val, rss_npc, lsb_val;
    logic [4:0]  next_id, dest_out, rd_out;
    logic        full, flush;
    logic [31:0] val_out, tgt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ro_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .is_issue_from_issuer  (iss),
        .rd_from_issuer        (rd),
        .pred_pc_from_issuer   (ppc),
        .is_branch_from_issuer (br),
        .next_rob_id_to_issuer (next_id),
        .is_ro_buffer_full     (full),
        .dest_from_rss_bus     (rss_dest),
        .value_from_rss_bus    (rss_val),
        .next_pc_from_rss_bus  (rss_npc),
        .dest_from_lsb_bus     (lsb_dest),
        .value_from_lsb_bus    (lsb_val),
        .dest_to_reg_file      (dest_out),
        .rd_to_reg_file        (rd_out),
        .value_to_reg_file     (val_out),
        .reset_to_rob_bus      (flush),
        .target_pc_to_rob_bus  (tgt)
    );

    typedef struct {
        logic        rst, rdy, iss, br;
        logic [4:0]  rd;
        logic [31:0] ppc;
        logic [4:0]  rdst;
        logic [31:0] rval, rnpc;
        logic [4:0]  ldst;
        logic [31:0] lval;
        logic [4:0]  e_dest, e_rd;
        logic [31:0] e_val;
        logic        e_flush;
        logic [31:0] e_tgt;
        logic [4:0]  e_id;
        logic        e_full;
    } vec_t;

    // Idle cycle with no commit, no flush, not full, given next id.
    function automatic vec_t nv(input int id);
        vec_t t;
        t.rst = 1'b0; t.rdy = 1'b1; t.iss = 1'b0; t.br = 1'b0;
        t.rd = 5'd0; t.ppc = 32'd0;
        t.rdst = 5'd0; t.rval = 32'd0; t.rnpc = 32'd0;
        t.ldst = 5'd0; t.lval = 32'd0;
        t.e_dest = 5'd0; t.e_rd = 5'd0; t.e_val = 32'd0;
        t.e_flush = 1'b0; t.e_tgt = 32'd0;
        t.e_id = 5'(id); t.e_full = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst = t.rst; rdy = t.rdy; iss = t.iss; br = t.br;
        rd = t.rd; ppc = t.ppc;
        rss_dest = t.rdst; rss_val = t.rval; rss_npc = t.rnpc;
        lsb_dest = t.ldst; lsb_val = t.lval;
        @(posedge clk);
        #1;
        chk("dest_to_reg_file",  idx, 32'(dest_out), 32'(t.e_dest));
        chk("rd_to_reg_file",    idx, 32'(rd_out),   32'(t.e_rd));
        chk("value_to_reg_file", idx, val_out,       t.e_val);
        chk("reset_to_rob_bus",  idx, 32'(flush),    32'(t.e_flush));
        chk("target_pc",         idx, tgt,           t.e_tgt);
        chk("next_rob_id",       idx, 32'(next_id),  32'(t.e_id));
        chk("is_full",           idx, 32'(full),     32'(t.e_full));
    endtask

    vec_t q[$];
    vec_t v;

    initial begin
        rst = 1'b1; rdy = 1'b1; iss = 1'b0; br = 1'b0; rd = 5'd0; ppc = 32'd0;
        rss_dest = 5'd0; rss_val = 32'd0; rss_npc = 32'd0;
        lsb_dest = 5'd0; lsb_val = 32'd0;

        // ---- basic issue / writeback / commit, plus issue alongside commit
        v = nv(1); v.rst = 1; q.push_back(v);
        v = nv(2); v.iss = 1; v.rd = 5; v.ppc = 32'h100; q.push_back(v);
        v = nv(2); v.rdst = 1; v.rval = 32'h2A; v.rnpc = 32'h104; q.push_back(v);
        v = nv(3); v.iss = 1; v.rd = 6; v.ppc = 32'h104;
                   v.e_dest = 1; v.e_rd = 5; v.e_val = 32'h2A; q.push_back(v);
        v = nv(3); v.rdst = 2; v.rval = 32'h3C; q.push_back(v);
        v = nv(3); v.e_dest = 2; v.e_rd = 6; v.e_val = 32'h3C; q.push_back(v);
        v = nv(3); q.push_back(v);

        // ---- out-of-order completion, in-order commit
        v = nv(1); v.rst = 1; q.push_back(v);
        v = nv(2); v.iss = 1; v.rd = 3; v.ppc = 32'h200; q.push_back(v);
        v = nv(3); v.iss = 1; v.rd = 4; v.ppc = 32'h204; q.push_back(v);
        v = nv(3); v.ldst = 2; v.lval = 32'h22; q.push_back(v);
        v = nv(3); v.rdst = 1; v.rval = 32'h11; v.rnpc = 32'h204; q.push_back(v);
        v = nv(3); v.e_dest = 1; v.e_rd = 3; v.e_val = 32'h11; q.push_back(v);
        v = nv(3); v.e_dest = 2; v.e_rd = 4; v.e_val = 32'h22; q.push_back(v);
        v = nv(3); q.push_back(v);

        // ---- both buses in the same cycle
        v = nv(1); v.rst = 1; q.push_back(v);
        v = nv(2); v.iss = 1; v.rd = 20; q.push_back(v);
        v = nv(3); v.iss = 1; v.rd = 21; q.push_back(v);
        v = nv(3); v.rdst = 2; v.rval = 32'hAA; v.ldst = 1; v.lval = 32'hBB; q.push_back(v);
        v = nv(3); v.e_dest = 1; v.e_rd = 20; v.e_val = 32'hBB; q.push_back(v);
        v = nv(3); v.e_dest = 2; v.e_rd = 21; v.e_val = 32'hAA; q.push_back(v);
        v = nv(3); q.push_back(v);

        // ---- mispredicted branch flushes younger entries
        v = nv(1); v.rst = 1; q.push_back(v);
        v = nv(2); v.iss = 1; v.rd = 1; v.ppc = 32'h104; v.br = 1; q.push_back(v);
        v = nv(3); v.iss = 1; v.rd = 2; v.ppc = 32'h108; q.push_back(v);
        v = nv(4); v.iss = 1; v.rd = 3; v.ppc = 32'h10C; v.ldst = 2; v.lval = 32'h77; q.push_back(v);
        v = nv(5); v.iss = 1; v.rd = 4; v.ppc = 32'h110;
                   v.rdst = 1; v.rval = 32'h55; v.rnpc = 32'h200; q.push_back(v);
        v = nv(1); v.rdst = 3; v.rval = 32'h9; v.rnpc = 32'h10C;
                   v.e_dest = 1; v.e_rd = 1; v.e_val = 32'h55;
                   v.e_flush = 1; v.e_tgt = 32'h200; q.push_back(v);
        v = nv(1); v.iss = 1; v.rd = 9; v.ppc = 32'h500; v.ldst = 2; v.lval = 32'h1; q.push_back(v);
        v = nv(1); q.push_back(v);
        v = nv(1); q.push_back(v);

        // ---- global stall during a pending commit
        v = nv(1); v.rst = 1; q.push_back(v);
        v = nv(2); v.iss = 1; v.rd = 7; v.ppc = 32'h300; q.push_back(v);
        v = nv(2); v.rdst = 1; v.rval = 32'h99; v.rnpc = 32'h304; q.push_back(v);
        v = nv(2); v.rdy = 0; v.iss = 1; v.rd = 8; q.push_back(v);
        v = nv(2); v.rdy = 0; v.iss = 1; v.rd = 8; q.push_back(v);
        v = nv(2); v.rdy = 0; q.push_back(v);
        v = nv(2); v.e_dest = 1; v.e_rd = 7; v.e_val = 32'h99; q.push_back(v);
        v = nv(2); v.rdy = 0; v.e_dest = 1; v.e_rd = 7; v.e_val = 32'h99; q.push_back(v);
        v = nv(2); q.push_back(v);

        // ---- reset with 8 busy entries and a commit about to happen
        v = nv(1); v.rst = 1; q.push_back(v);
        for (int k = 0; k < 8; k++) begin
            v = nv(k + 2); v.iss = 1; v.rd = 5'(k + 10); v.ppc = 32'(k * 4); q.push_back(v);
        end
        v = nv(9); v.rdst = 1; v.rval = 32'h1; q.push_back(v);
        v = nv(1); v.rst = 1; v.iss = 1; v.rd = 3; v.ldst = 2; v.lval = 32'h5; q.push_back(v);
        v = nv(1); q.push_back(v);
        v = nv(1); q.push_back(v);

        for (int i = 0; i < q.size(); i++) begin
            apply(q[i], i);
        end

        // ---- fill to capacity: full at 15, 16th accepted, 17th ignored
        v = nv(1); v.rst = 1; apply(v, 1000);
        for (int i = 0; i < 15; i++) begin
            v = nv(i + 2); v.iss = 1; v.rd = 5'(i + 1); v.e_full = (i >= 14);
            apply(v, 1001 + i);
        end
        v = nv(1); v.iss = 1; v.rd = 16; v.e_full = 1; apply(v, 1016);
        v = nv(1); v.iss = 1; v.rd = 17; v.e_full = 1; apply(v, 1017);
        v = nv(1); v.rdst = 1; v.rval = 32'h5; v.e_full = 1; apply(v, 1018);
        v = nv(1); v.e_full = 1; v.e_dest = 1; v.e_rd = 1; v.e_val = 32'h5; apply(v, 1019);
        v = nv(1); v.e_full = 1; apply(v, 1020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
